// File: rtl/dl_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : dl_serial_subtractor
//  Description : Digit-serial unsigned/signed subtractor, DIGIT_BITS per cycle,
//                valid/ready handshake on both sides, borrow and overflow flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module dl_serial_subtractor #(
    parameter int NUM_BITS   = 32,
    parameter int DIGIT_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NUM_BITS-1:0] a,
    input  logic [NUM_BITS-1:0] b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NUM_BITS-1:0] diff,
    output logic                bout,
    output logic                ovf
);

    localparam int N     = NUM_BITS / DIGIT_BITS;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic [NUM_BITS-1:0] a_q;
    logic [NUM_BITS-1:0] b_q;
    logic [NUM_BITS-1:0] diff_q;
    logic                borrow_q;
    logic                bout_q;
    logic                ovf_q;
    logic                a_msb_q;
    logic                b_msb_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic [CNT_W-1:0]    cnt_q;

    logic [DIGIT_BITS:0] sub_d;
    logic                last_d;

    // Extra top bit of the digit difference is the digit borrow-out.
    always_comb begin
        sub_d  = {1'b0, a_q[DIGIT_BITS-1:0]} - {1'b0, b_q[DIGIT_BITS-1:0]}
                 - {{DIGIT_BITS{1'b0}}, borrow_q};
        last_d = (cnt_q == LAST_CNT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
            bout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        a_msb_q    <= a[NUM_BITS-1];
                        b_msb_q    <= b[NUM_BITS-1];
                        borrow_q   <= 1'b0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    diff_q[cnt_q*DIGIT_BITS +: DIGIT_BITS] <= sub_d[DIGIT_BITS-1:0];
                    borrow_q <= sub_d[DIGIT_BITS];
                    a_q      <= a_q >> DIGIT_BITS;
                    b_q      <= b_q >> DIGIT_BITS;
                    cnt_q    <= cnt_q + 1'b1;
                    if (last_d) begin
                        // Flags only change on the final digit so they stay
                        // coherent with the completed diff.
                        bout_q      <= sub_d[DIGIT_BITS];
                        ovf_q       <= (a_msb_q != b_msb_q) &&
                                       (sub_d[DIGIT_BITS-1] != a_msb_q);
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_dl_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dl_serial_subtractor
//  Description : Directed self-checking bench for dl_serial_subtractor (32/8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dl_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] diff;
    logic        bout;
    logic        ovf;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dl_serial_subtractor #(
        .NUM_BITS   (32),
        .DIGIT_BITS (8)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge with the DUT idle; returns #1 after the accept edge.
    task automatic start_op(input string tag, input logic [31:0] va, input logic [31:0] vb);
        chk({tag, ".in_ready_pre"}, 64'(in_ready), 64'd1);
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        chk({tag, ".in_ready_busy"}, 64'(in_ready), 64'd0);
    endtask

    task automatic wait_done(input string tag);
        int lat;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            a = $urandom;
            b = $urandom;
        end
        chk({tag, ".latency"}, 64'(lat), 64'd4);
    endtask

    task automatic chk_result(input string tag, input logic [31:0] ed, input logic eb, input logic eo);
        chk({tag, ".diff"}, 64'(diff), 64'(ed));
        chk({tag, ".bout"}, 64'(bout), 64'(eb));
        chk({tag, ".ovf"},  64'(ovf),  64'(eo));
    endtask

    task automatic release_result(input string tag, input logic [31:0] ed);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, ".out_valid_rel"}, 64'(out_valid), 64'd0);
        chk({tag, ".in_ready_rel"},  64'(in_ready),  64'd1);
        chk({tag, ".diff_held"},     64'(diff),      64'(ed));
    endtask

    task automatic run_op(input string tag, input logic [31:0] va, input logic [31:0] vb,
                          input logic [31:0] ed, input logic eb, input logic eo);
        start_op(tag, va, vb);
        wait_done(tag);
        chk_result(tag, ed, eb, eo);
        release_result(tag, ed);
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        #1 rst = 1'b1;
        #1;
        chk("rst.in_ready",  64'(in_ready),  64'd1);
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk_result("rst", 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        run_op("v5m3",   32'd5,          32'd3,          32'h0000_0002, 1'b0, 1'b0);
        run_op("v3m5",   32'd3,          32'd5,          32'hFFFF_FFFE, 1'b1, 1'b0);
        run_op("vminm1", 32'h8000_0000,  32'd1,          32'h7FFF_FFFF, 1'b0, 1'b1);
        run_op("vposov", 32'h7FFF_FFFF,  32'hFFFF_FFFF,  32'h8000_0000, 1'b1, 1'b1);

        // Borrow ripple, then a long stall in DONE with stray in_valid pulses.
        start_op("ripple", 32'h0000_00FF, 32'hFFFF_FF00);
        wait_done("ripple");
        chk_result("ripple", 32'h0000_01FF, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            a        = $urandom;
            b        = $urandom;
            @(posedge clk);
            #1;
            chk("stall.out_valid", 64'(out_valid), 64'd1);
            chk("stall.in_ready",  64'(in_ready),  64'd0);
            chk_result("stall", 32'h0000_01FF, 1'b1, 1'b0);
        end
        in_valid = 1'b0;
        release_result("ripple", 32'h0000_01FF);

        // Idle cycles leave the previous result untouched.
        repeat (3) @(posedge clk);
        #1;
        chk_result("idle", 32'h0000_01FF, 1'b1, 1'b0);

        // Reset during the second BUSY cycle abandons the operation.
        start_op("rstbusy", 32'h1111_1111, 32'h2222_2222);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rstbusy.in_ready",  64'(in_ready),  64'd1);
        chk("rstbusy.out_valid", 64'(out_valid), 64'd0);
        chk_result("rstbusy", 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 8; i++) begin
                @(posedge clk);
                #1;
                if (out_valid) seen = 1'b1;
            end
            chk("rstbusy.no_result", 64'(seen), 64'd0);
        end
        run_op("v10m10", 32'd10, 32'd10, 32'h0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
